// File: rtl/apu_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : apu_frame_sequencer_if
// Brief    : CPU register strobes in, frame strobes / IRQ / mode status out.
// Revision : 1.0 - initial release
// ============================================================================
interface apu_frame_sequencer_if;
    logic       wr_4017;
    logic [7:0] wr_data;
    logic       rd_4015;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic       mode5;

    modport master (
        output wr_4017, wr_data, rd_4015,
        input  quarter_frame, half_frame, frame_irq, mode5
    );

    modport slave (
        input  wr_4017, wr_data, rd_4015,
        output quarter_frame, half_frame, frame_irq, mode5
    );
endinterface
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : apu_frame_sequencer
// Brief    : APU frame counter - quarter/half frame strobes and frame IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module apu_frame_sequencer #(
    parameter int STEP1   = 7457,
    parameter int STEP2   = 14913,
    parameter int STEP3   = 22371,
    parameter int STEP4   = 29829,
    parameter int PERIOD4 = 29830,
    parameter int STEP5   = 37281,
    parameter int PERIOD5 = 37282,
    parameter int CW      = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    apu_frame_sequencer_if.slave  bus
);

    localparam logic [CW-1:0] c_step1    = CW'(STEP1);
    localparam logic [CW-1:0] c_step2    = CW'(STEP2);
    localparam logic [CW-1:0] c_step3    = CW'(STEP3);
    localparam logic [CW-1:0] c_step4    = CW'(STEP4);
    localparam logic [CW-1:0] c_step5    = CW'(STEP5);
    localparam logic [CW-1:0] c_last4    = CW'(PERIOD4 - 1);
    localparam logic [CW-1:0] c_prelast4 = CW'(PERIOD4 - 2);
    localparam logic [CW-1:0] c_last5    = CW'(PERIOD5 - 1);
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [2:0]    c_dly_even = 3'd3;
    localparam logic [2:0]    c_dly_odd  = 3'd4;

    logic [CW-1:0] r_cyc;
    logic [2:0]    r_dly;
    logic          r_mode5;
    logic          r_irq_inhibit;
    logic          r_frame_irq;
    logic          r_quarter;
    logic          r_half;
    logic          r_phase;
    logic          r_wrapped4;
    logic          r_pend_mode;
    logic          r_kick;

    logic          w_last;
    logic          w_apply;
    logic          w_quarter_hit;
    logic          w_half_hit;
    logic          w_irq_set;
    logic          w_irq_next;

    assign w_last = r_mode5 ? (r_cyc == c_last5) : (r_cyc == c_last4);

    // A new write landing on the final delay tick restarts the delay instead.
    assign w_apply = (r_dly == 3'd1) && !bus.wr_4017;

    assign w_quarter_hit = (r_cyc == c_step1) || (r_cyc == c_step2) || (r_cyc == c_step3)
                         || (!r_mode5 && (r_cyc == c_step4))
                         || ( r_mode5 && (r_cyc == c_step5));

    assign w_half_hit = (r_cyc == c_step2)
                      || (!r_mode5 && (r_cyc == c_step4))
                      || ( r_mode5 && (r_cyc == c_step5));

    assign w_irq_set = !r_mode5 && !r_irq_inhibit
                     && ((r_cyc == c_prelast4) || (r_cyc == c_last4) || r_wrapped4);

    // Inhibit write beats a set, and a set beats a status-read clear.
    always_comb begin
        w_irq_next = r_frame_irq;
        if (bus.wr_4017 && bus.wr_data[6]) begin
            w_irq_next = 1'b0;
        end else if (w_irq_set) begin
            w_irq_next = 1'b1;
        end else if (bus.rd_4015) begin
            w_irq_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc         <= '0;
            r_dly         <= '0;
            r_mode5       <= 1'b0;
            r_irq_inhibit <= 1'b0;
            r_frame_irq   <= 1'b0;
            r_quarter     <= 1'b0;
            r_half        <= 1'b0;
            r_phase       <= 1'b0;
            r_wrapped4    <= 1'b0;
            r_pend_mode   <= 1'b0;
            r_kick        <= 1'b0;
        end else begin
            r_phase     <= ~r_phase;
            r_wrapped4  <= !r_mode5 && (r_cyc == c_last4);
            r_frame_irq <= w_irq_next;
            r_kick      <= w_apply && r_pend_mode;
            r_quarter   <= w_quarter_hit || r_kick;
            r_half      <= w_half_hit || r_kick;

            if (w_apply || w_last) begin
                r_cyc <= '0;
            end else begin
                r_cyc <= r_cyc + c_one;
            end

            if (w_apply) begin
                r_mode5 <= r_pend_mode;
            end

            if (bus.wr_4017) begin
                r_irq_inhibit <= bus.wr_data[6];
                r_pend_mode   <= bus.wr_data[7];
                r_dly         <= r_phase ? c_dly_odd : c_dly_even;
            end else if (r_dly != 3'd0) begin
                r_dly <= r_dly - 3'd1;
            end
        end
    end

    assign bus.quarter_frame = r_quarter;
    assign bus.half_frame    = r_half;
    assign bus.frame_irq     = r_frame_irq;
    assign bus.mode5         = r_mode5;

endmodule
`default_nettype wire

// File: tb/tb_apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_frame_sequencer
// Brief    : Directed vector bench for the APU frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apu_frame_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #5 clk = ~clk;

    apu_frame_sequencer_if bus ();
    apu_frame_sequencer_if sbus ();

    apu_frame_sequencer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Shortened sequence so a full inhibited 4-step run stays cheap.
    apu_frame_sequencer #(
        .STEP1   (10),
        .STEP2   (20),
        .STEP3   (30),
        .STEP4   (40),
        .PERIOD4 (41),
        .STEP5   (50),
        .PERIOD5 (51),
        .CW      (16)
    ) u_small (
        .clk (clk),
        .rst (rst_s),
        .bus (sbus.slave)
    );

    typedef struct {
        int         g;
        bit         rst;
        bit         wr;
        logic [7:0] data;
        bit         rd;
        bit         q;
        bit         h;
        bit         irq;
        bit         m5;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   bad    = 0;
    int   edge_n = 0;
    int   qcnt   = 0;
    int   hcnt   = 0;

    always @(negedge clk) begin
        if (bus.quarter_frame) qcnt <= qcnt + 1;
        if (bus.half_frame)    hcnt <= hcnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void add(input int g, input bit r, input bit w, input logic [7:0] d,
                                input bit rd, input bit q, input bit h, input bit irq,
                                input bit m5, input string name);
        vec_t v;
        v.g = g; v.rst = r; v.wr = w; v.data = d; v.rd = rd;
        v.q = q; v.h = h; v.irq = irq; v.m5 = m5; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            while (edge_n < vecs[i].g - 1) step();
            rst         = vecs[i].rst;
            bus.wr_4017 = vecs[i].wr;
            bus.wr_data = vecs[i].data;
            bus.rd_4015 = vecs[i].rd;
            step();
            rst         = 1'b0;
            bus.wr_4017 = 1'b0;
            bus.wr_data = 8'h00;
            bus.rd_4015 = 1'b0;
            check({vecs[i].name, ".quarter"}, int'(bus.quarter_frame), int'(vecs[i].q));
            check({vecs[i].name, ".half"},    int'(bus.half_frame),    int'(vecs[i].h));
            check({vecs[i].name, ".irq"},     int'(bus.frame_irq),     int'(vecs[i].irq));
            check({vecs[i].name, ".mode5"},   int'(bus.mode5),         int'(vecs[i].m5));
        end
    endtask

    // B: last reset edge of the mid-run reset; C: 5-step sequence start.
    localparam int B = 20002;
    localparam int C = B + 29836;

    initial begin
        int seg0, seg1, seg2, seg3;
        int qmark, hmark;
        bit irq_seen;

        rst = 1'b1; rst_s = 1'b1;
        bus.wr_4017 = 1'b0; bus.wr_data = 8'h00; bus.rd_4015 = 1'b0;
        sbus.wr_4017 = 1'b0; sbus.wr_data = 8'h00; sbus.rd_4015 = 1'b0;

        //   g          rst wr data   rd q  h  irq m5  name
        add(7457,       0, 0, 8'h00, 0, 0, 0, 0, 0, "pre_s1_early");
        add(7458,       0, 0, 8'h00, 0, 1, 0, 0, 0, "pre_s1");
        add(14914,      0, 0, 8'h00, 0, 1, 1, 0, 0, "pre_s2");
        add(19999,      0, 1, 8'h80, 0, 0, 0, 0, 0, "pre_wr80");
        add(20001,      1, 0, 8'h00, 0, 0, 0, 0, 0, "rst_mid");
        add(B,          1, 0, 8'h00, 0, 0, 0, 0, 0, "rst_hold");
        add(B + 1,      0, 0, 8'h00, 0, 0, 0, 0, 0, "rst_no_kick");
        seg0 = vecs.size();
        add(B + 7457,   0, 0, 8'h00, 0, 0, 0, 0, 0, "s1_early");
        add(B + 7458,   0, 0, 8'h00, 0, 1, 0, 0, 0, "s1_q1");
        add(B + 7459,   0, 0, 8'h00, 0, 0, 0, 0, 0, "s1_q1_end");
        add(B + 14914,  0, 0, 8'h00, 0, 1, 1, 0, 0, "s1_q2");
        add(B + 22372,  0, 0, 8'h00, 0, 1, 0, 0, 0, "s1_q3");
        add(B + 29828,  0, 0, 8'h00, 0, 0, 0, 0, 0, "s1_irq_pre");
        add(B + 29829,  0, 0, 8'h00, 1, 0, 0, 1, 0, "s1_set_vs_rd");
        add(B + 29830,  0, 0, 8'h00, 0, 1, 1, 1, 0, "s1_q4");
        add(B + 29831,  0, 0, 8'h00, 1, 0, 0, 1, 0, "s1_wrap_set_vs_rd");
        add(B + 29832,  0, 0, 8'h00, 1, 0, 0, 0, 0, "s1_rd_clear");
        seg1 = vecs.size();
        add(B + 29833,  0, 1, 8'h80, 0, 0, 0, 0, 0, "m5_wr");
        add(B + 29835,  0, 0, 8'h00, 0, 0, 0, 0, 0, "m5_wait");
        add(C,          0, 0, 8'h00, 0, 0, 0, 0, 1, "m5_apply");
        add(C + 1,      0, 0, 8'h00, 0, 1, 1, 0, 1, "m5_kick");
        add(C + 2,      0, 0, 8'h00, 0, 0, 0, 0, 1, "m5_kick_end");
        add(C + 7458,   0, 0, 8'h00, 0, 1, 0, 0, 1, "m5_q1");
        add(C + 14914,  0, 0, 8'h00, 0, 1, 1, 0, 1, "m5_q2");
        add(C + 22372,  0, 0, 8'h00, 0, 1, 0, 0, 1, "m5_q3");
        add(C + 29829,  0, 0, 8'h00, 0, 0, 0, 0, 1, "m5_no_irq_a");
        add(C + 29830,  0, 0, 8'h00, 0, 0, 0, 0, 1, "m5_no_step4");
        add(C + 29831,  0, 0, 8'h00, 0, 0, 0, 0, 1, "m5_no_irq_b");
        add(C + 37282,  0, 0, 8'h00, 0, 1, 1, 0, 1, "m5_step5");
        add(C + 37283,  0, 0, 8'h00, 0, 0, 0, 0, 1, "m5_step5_end");
        seg2 = vecs.size();
        add(B + 67120,  0, 1, 8'h80, 0, 0, 0, 0, 1, "dbl_wr1");
        add(B + 67122,  0, 1, 8'h00, 0, 0, 0, 0, 1, "dbl_wr2");
        add(B + 67124,  0, 0, 8'h00, 0, 0, 0, 0, 1, "dbl_old_apply");
        add(B + 67125,  0, 0, 8'h00, 0, 0, 0, 0, 1, "dbl_no_kick");
        add(B + 67126,  0, 0, 8'h00, 0, 0, 0, 0, 0, "dbl_apply");
        add(B + 67127,  0, 0, 8'h00, 0, 0, 0, 0, 0, "dbl_quiet");
        seg3 = vecs.size();

        repeat (3) step();
        rst = 1'b0;
        edge_n = 0;
        check("reset.quarter", int'(bus.quarter_frame), 0);
        check("reset.half",    int'(bus.half_frame),    0);
        check("reset.irq",     int'(bus.frame_irq),     0);
        check("reset.mode5",   int'(bus.mode5),         0);

        run_vecs(0, seg0);
        qmark = qcnt; hmark = hcnt;
        run_vecs(seg0, seg1);
        check("s1_quarter_count", qcnt - qmark, 4);
        check("s1_half_count",    hcnt - hmark, 2);
        qmark = qcnt; hmark = hcnt;
        run_vecs(seg1, seg2);
        check("m5_quarter_count", qcnt - qmark, 5);
        check("m5_half_count",    hcnt - hmark, 3);
        run_vecs(seg2, seg3);

        // Short-sequence instance: inhibit write clears a live IRQ, then a
        // whole 4-step sequence must run without raising it.
        rst_s = 1'b0;
        repeat (39) step();
        check("sm_irq_pre", int'(sbus.frame_irq), 0);
        step();
        check("sm_irq_set", int'(sbus.frame_irq), 1);
        sbus.wr_4017 = 1'b1; sbus.wr_data = 8'h40;
        step();
        sbus.wr_4017 = 1'b0; sbus.wr_data = 8'h00;
        check("sm_inhibit_clear", int'(sbus.frame_irq), 0);
        irq_seen = 1'b0;
        for (int k = 42; k <= 90; k++) begin
            step();
            irq_seen = irq_seen | sbus.frame_irq;
            if (k == 55) check("sm_q1", int'(sbus.quarter_frame), 1);
            if (k == 85) begin
                check("sm_q4.quarter", int'(sbus.quarter_frame), 1);
                check("sm_q4.half",    int'(sbus.half_frame),    1);
            end
        end
        check("sm_irq_stays_low", int'(irq_seen), 0);
        check("sm_mode5", int'(sbus.mode5), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
- Frame counter for the APU: counts CPU clocks and issues one-clock quarter_frame and half_frame strobes.
- quarter_frame clocks the envelope units of the channel blocks (noise, pulse, triangle linear counter); half_frame clocks their length counters.
- Configured by CPU writes to $4017. Generates the frame IRQ; the $4015 status read logic clears it.

Parameters:
- STEP1, 7457, CPU-cycle count of step 1
- STEP2, 14913, count of step 2
- STEP3, 22371, count of step 3
- STEP4, 29829, count of step 4 (4-step mode)
- PERIOD4, 29830, 4-step sequence length; counter wraps to 0 after PERIOD4-1
- STEP5, 37281, count of final step (5-step mode)
- PERIOD5, 37282, 5-step sequence length
- CW, 16, cycle counter width; must hold PERIOD5-1

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous reset, active-high
- wr_4017  in  1  one-clock write strobe for $4017
- wr_data  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit
- rd_4015  in  1  one-clock status-read strobe; clears frame_irq
- quarter_frame  out  1  one-clock envelope/linear clock strobe
- half_frame  out  1  one-clock length/sweep clock strobe
- frame_irq  out  1  frame interrupt flag, level
- mode5  out  1  current sequence mode (0 = 4-step, 1 = 5-step)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: cyc=0, mode5=0, irq_inhibit=0, frame_irq=0, quarter_frame=0, half_frame=0, phase=0, write-delay idle. Reset mid-sequence or mid-delay discards all state, including any pending write.
- phase toggles every clk (CPU odd/even cycle).
- cyc increments every clk and wraps to 0 when cyc==PERIODx-1 (PERIOD4 if mode5=0, else PERIOD5). No other wrap point exists.
- Strobes are registered: each asserts in the clk cycle after the cycle in which cyc equals the step value, for exactly one clk.
- 4-step mode strobes:
  - quarter at STEP1, STEP2, STEP3, STEP4.
  - half at STEP2, STEP4.
- 5-step mode strobes:
  - quarter at STEP1, STEP2, STEP3, STEP5.
  - half at STEP2, STEP5.
  - Nothing at STEP4.
- IRQ set: only in 4-step mode with irq_inhibit=0, frame_irq is set (registered) when cyc==PERIOD4-2, when cyc==PERIOD4-1, and in the first cycle after the wrap (cyc==0, flagged by a wrapped4 register). Repeated sets are idempotent.
- IRQ clear: rd_4015 clears frame_irq next clk. If a set and a clear occur in the same cycle, the set wins.
- Write, immediate effects: irq_inhibit <= wr_data[6]. If wr_data[6]=1, frame_irq clears next clk and overrides any set in the same cycle.
- Write, delayed effects: the pending mode (wr_data[7]) is latched and the delay counter is loaded with 3 if phase==0 at the write, else 4.
  - The counter decrements each clk.
  - When it reaches 0: cyc<=0 and mode5<=pending mode, both in the same clk.
  - If the pending mode is 1, quarter_frame and half_frame both pulse in the following clk, regardless of cyc.
- During the delay, the sequence continues under the old mode, and any step hit still produces its strobes.
- A second wr_4017 during the delay restarts the delay with the new data. The first write's mode is discarded.
- Only one strobe set is produced per cycle; coinciding causes do not double-pulse.
- wr_4017 and rd_4015 in the same clk are both honoured. Inhibit takes priority for frame_irq.

Test Plan:
- Reset, then run 30000 clks in 4-step mode -> quarter at cycles 7458, 14914, 22372, 29830; half only at 14914 and 29830; frame_irq rises at 29829 and stays high.
- With frame_irq=1, pulse rd_4015 -> frame_irq=0 next clk. Pulse rd_4015 in the same clk as a set at cyc==29828 -> frame_irq stays 1.
- Write wr_data=8'h80 with phase=0 -> mode5=1 and cyc=0 after 3 clks, quarter+half pulse one clk later. Then run 37282 clks -> strobes at steps 7457/14913/22371/37281 offsets, no strobe at 29829, frame_irq never set.
- Write with phase=1 -> reset delay is 4 clks. Second write 2 clks later with 8'h00 -> delay restarts, final mode5=0, no immediate strobe.
- Write 8'h40 while frame_irq=1 -> frame_irq=0 next clk. Run a full 4-step sequence -> frame_irq stays 0.
- Assert rst at cyc=20000 and during a pending write delay -> all outputs 0, mode5=0, next quarter exactly STEP1+1 clks after rst deasserts.
